// File: rtl/mixpix_rlbp_la_core.sv
// MixPix user core: LA-loaded 3x3 neighbourhood -> LBP / rotation-invariant LBP,
// compared against an expected code; status mirrored on GPIO io[31:16].
//   state | meaning
//   IDLE  | waiting for start event
//   BUSY  | plain LBP, result written next edge
//   ROT   | eight right-rotations, tracking the minimum
//   DONE  | result held, match valid, restartable
module mixpix_rlbp_la_core #(
  parameter logic [7:0] CHK_TAG = 8'hAB
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oenb,
  output logic [127:0] la_data_out,
  output logic [37:0]  io_out,
  output logic [37:0]  io_oeb
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ROT  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     r_state;
  logic [7:0] r_raw;
  logic [7:0] r_cur;
  logic [7:0] r_best;
  logic [7:0] r_result;
  logic [7:0] r_exp;
  logic       r_mode;
  logic [2:0] r_cnt;
  logic       r_start_d;

  logic [7:0] w_raw;
  logic [7:0] w_cur_rot;
  logic [7:0] w_best_next;
  logic       w_start_q;
  logic       w_start_ev;
  logic       w_done;
  logic       w_busy;
  logic       w_match;
  logic [7:0] w_status;
  logic       w_unused;

  always_comb begin
    w_raw = 8'h00;
    for (int i = 0; i < 8; i++) begin
      w_raw[i] = (la_data_in[8*i +: 8] >= la_data_in[71:64]);
    end
  end

  assign w_start_q   = la_data_in[96] & ~la_oenb[96];
  assign w_start_ev  = w_start_q & ~r_start_d;
  assign w_cur_rot   = {r_cur[0], r_cur[7:1]};
  assign w_best_next = (w_cur_rot < r_best) ? w_cur_rot : r_best;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_raw     <= 8'h00;
      r_cur     <= 8'h00;
      r_best    <= 8'h00;
      r_result  <= 8'h00;
      r_exp     <= 8'h00;
      r_mode    <= 1'b0;
      r_cnt     <= 3'd0;
      r_start_d <= 1'b0;
    end else begin
      r_start_d <= w_start_q;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ev) begin
            r_raw   <= w_raw;
            r_cur   <= w_raw;
            r_best  <= w_raw;
            r_exp   <= la_data_in[79:72];
            r_mode  <= la_data_in[97];
            r_cnt   <= 3'd0;
            r_state <= la_data_in[97] ? S_ROT : S_BUSY;
          end
        end
        S_BUSY: begin
          r_result <= r_raw;
          r_state  <= S_DONE;
        end
        S_ROT: begin
          r_cur  <= w_cur_rot;
          r_best <= w_best_next;
          r_cnt  <= r_cnt + 3'd1;
          // eighth rotation brings cur back to raw; min is final here
          if (r_cnt == 3'd7) begin
            r_result <= w_best_next;
            r_state  <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_done  = (r_state == S_DONE);
  assign w_busy  = (r_state == S_BUSY) || (r_state == S_ROT);
  assign w_match = w_done && (r_result == r_exp);

  always_comb begin
    w_status = 8'h40;
    if (w_busy)      w_status = 8'h41;
    else if (w_done) w_status = w_match ? 8'h51 : 8'h50;
  end

  assign la_data_out = {109'd0, w_busy, w_match, w_done, r_result, r_raw};
  assign io_out      = {6'd0, CHK_TAG, w_status, 16'd0};
  assign io_oeb      = {6'h3F, 16'h0000, 16'hFFFF};

  assign w_unused = ^{la_data_in[127:98], la_oenb[127:97], la_oenb[95:0], r_mode};

endmodule

// File: tb/tb_mixpix_rlbp_la_core.sv
// Randomized bench for mixpix_rlbp_la_core against an arithmetic LBP/RLBP model.
module tb_mixpix_rlbp_la_core;

  logic         wb_clk_i;
  logic         wb_rst_i;
  logic [127:0] la_data_in;
  logic [127:0] la_oenb;
  logic [127:0] la_data_out;
  logic [37:0]  io_out;
  logic [37:0]  io_oeb;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_pix [8];
  logic [7:0] m_c;
  logic [7:0] m_exp;
  logic       m_mode;

  mixpix_rlbp_la_core #(.CHK_TAG(8'hAB)) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .la_data_in (la_data_in),
    .la_oenb    (la_oenb),
    .la_data_out(la_data_out),
    .io_out     (io_out),
    .io_oeb     (io_oeb)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_raw();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = (m_pix[i] >= m_c);
    return r;
  endfunction

  // minimum over all eight cyclic rotations of the code
  function automatic logic [7:0] model_rlbp(input logic [7:0] x);
    logic [15:0] d;
    logic [15:0] s;
    logic [7:0]  best;
    d = {x, x};
    best = x;
    for (int k = 0; k < 8; k++) begin
      s = d >> k;
      if (s[7:0] < best) best = s[7:0];
    end
    return best;
  endfunction

  task automatic drive_inputs(input logic start);
    for (int i = 0; i < 8; i++) la_data_in[8*i +: 8] = m_pix[i];
    la_data_in[71:64] = m_c;
    la_data_in[79:72] = m_exp;
    la_data_in[96]    = start;
    la_data_in[97]    = m_mode;
  endtask

  task automatic run_op(input bit scramble, input bit pulse);
    logic [7:0] e_raw, e_res;
    int n;
    e_raw = model_raw();
    e_res = m_mode ? model_rlbp(e_raw) : e_raw;
    @(negedge wb_clk_i);
    drive_inputs(1'b0);
    @(negedge wb_clk_i);
    la_data_in[96] = 1'b1;
    @(posedge wb_clk_i);
    #1;
    chk("busy_after_start", {63'd0, la_data_out[18]}, 64'd1);
    chk("status_busy", {48'd0, io_out[31:16]}, 64'hAB41);
    chk("raw", {56'd0, la_data_out[7:0]}, {56'd0, e_raw});
    if (scramble) la_data_in[79:0] = {$urandom, $urandom, $urandom};
    n = 0;
    while (la_data_out[16] == 1'b0 && n < 20) begin
      @(negedge wb_clk_i);
      if (pulse && n == 1) la_data_in[96] = 1'b0;
      if (pulse && n == 3) la_data_in[96] = 1'b1;
      @(posedge wb_clk_i);
      #1;
      n++;
      if (la_data_out[16] == 1'b0)
        chk("status_during_op", {48'd0, io_out[31:16]}, 64'hAB41);
    end
    chk("latency", n, m_mode ? 8 : 1);
    chk("raw_done", {56'd0, la_data_out[7:0]}, {56'd0, e_raw});
    chk("result", {56'd0, la_data_out[15:8]}, {56'd0, e_res});
    chk("match", {63'd0, la_data_out[17]}, {63'd0, (e_res == m_exp)});
    chk("busy_done", {63'd0, la_data_out[18]}, 64'd0);
    chk("status_done", {48'd0, io_out[31:16]}, (e_res == m_exp) ? 64'hAB51 : 64'hAB50);
    chk("upper_zero", {45'd0, la_data_out[127:109]}, 64'd0);
    @(negedge wb_clk_i);
    la_data_in[96] = 1'b0;
    @(posedge wb_clk_i);
    #1;
    chk("result_hold", {56'd0, la_data_out[15:8]}, {56'd0, e_res});
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_io"}, {48'd0, io_out[31:16]}, 64'hAB40);
    chk({tag, "_la_lo"}, la_data_out[63:0], 64'd0);
    chk({tag, "_la_hi"}, la_data_out[127:64], 64'd0);
  endtask

  task automatic set_case(input logic [7:0] c, input logic [7:0] p, input logic [7:0] e, input logic md);
    for (int i = 0; i < 8; i++) m_pix[i] = p;
    m_c = c; m_exp = e; m_mode = md;
  endtask

  initial begin
    wb_rst_i   = 1'b1;
    la_data_in = '0;
    la_oenb    = '0;
    for (int i = 0; i < 8; i++) m_pix[i] = 8'h00;
    m_c = 0; m_exp = 0; m_mode = 0;
    #2;
    check_reset_outputs("reset");
    chk("io_oeb", {26'd0, io_oeb}, {26'd0, 6'h3F, 16'h0000, 16'hFFFF});
    chk("io_out_other", {32'd0, io_out[37:32], io_out[15:0]}, 64'd0);
    repeat (2) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;

    // start gated off by la_oenb
    la_oenb[96] = 1'b1;
    la_data_in[96] = 1'b1;
    repeat (5) @(posedge wb_clk_i);
    #1;
    chk("oenb_gate_status", {48'd0, io_out[31:16]}, 64'hAB40);
    chk("oenb_gate_busy", {63'd0, la_data_out[18]}, 64'd0);
    @(negedge wb_clk_i);
    la_data_in[96] = 1'b0;
    @(negedge wb_clk_i);
    la_oenb[96] = 1'b0;

    set_case(8'h80, 8'h10, 8'h09, 1'b1);
    m_pix[1] = 8'h80; m_pix[4] = 8'h80;
    run_op(1'b0, 1'b0);
    m_mode = 1'b0; m_exp = 8'h12;
    run_op(1'b0, 1'b0);
    m_exp = 8'h13;
    run_op(1'b0, 1'b0);
    m_mode = 1'b1; m_exp = 8'h09;
    run_op(1'b0, 1'b1);
    run_op(1'b1, 1'b0);

    set_case(8'h00, 8'hFF, 8'hFF, 1'b1);
    run_op(1'b0, 1'b0);
    set_case(8'h01, 8'h00, 8'h00, 1'b1);
    run_op(1'b0, 1'b0);

    for (int it = 0; it < 40; it++) begin
      m_c = 8'($urandom);
      for (int i = 0; i < 8; i++)
        m_pix[i] = ($urandom_range(0, 2) == 0) ? m_c : 8'($urandom);
      m_mode = 1'($urandom);
      m_exp = 8'($urandom);
      if ($urandom_range(0, 1) == 1)
        m_exp = m_mode ? model_rlbp(model_raw()) : model_raw();
      run_op(m_mode && ($urandom_range(0, 1) == 1), m_mode && ($urandom_range(0, 3) == 0));
    end

    // asynchronous reset in the middle of a rotation
    set_case(8'h80, 8'h90, 8'h00, 1'b1);
    @(negedge wb_clk_i);
    drive_inputs(1'b0);
    @(negedge wb_clk_i);
    la_data_in[96] = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rot_before_reset", {48'd0, io_out[31:16]}, 64'hAB41);
    #2;
    wb_rst_i = 1'b1;
    #1;
    check_reset_outputs("reset_mid_rot");
    @(posedge wb_clk_i);
    #1;
    check_reset_outputs("reset_held");
    la_data_in[96] = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("idle_after_reset", {48'd0, io_out[31:16]}, 64'hAB40);
    run_op(1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mixpix_rlbp_la_core.md
Name: mixpix_rlbp_la_core

Overview:
User-project core of the MixPix chip, sitting in the user area and driven entirely from the management SoC over the 128-bit logic analyzer (LA).
- Firmware loads a 3x3 pixel neighbourhood, an expected code and a mode, then pulses start.
- The block computes an 8-bit local binary pattern (LBP), or its rotation-invariant minimum (RLBP), and compares it with the expected code.
- It reports result and status on LA outputs, plus a 16-bit checkpoint word on user GPIO io[31:16].

Parameters:
CHK_TAG, 8'hAB, upper byte of the GPIO checkpoint word.

Ports:
wb_clk_i  in  1  system clock; all state on rising edge
wb_rst_i  in  1  asynchronous active-high reset
la_data_in  in  128  LA data from management SoC
la_oenb  in  128  LA output-enable, active low; bit=0 means the SoC drives that bit
la_data_out  out  128  LA data to management SoC
io_out  out  38  user GPIO outputs
io_oeb  out  38  user GPIO output-enable, active low

Behaviour:
LA input map:
- Neighbour P_i = la_data_in[8i+7:8i], i=0..7.
- Center C = [71:64].
- Expected code EXP = [79:72].
- start = [96].
- mode = [97]: 0 = plain LBP, 1 = rotation-invariant minimum.

Start qualification:
- start_q = la_data_in[96] & ~la_oenb[96].
- Registered once per cycle; a rising edge (start_q=1, previous=0) is a start event.

Raw code:
- Bit i = (P_i >= C), unsigned compare; equal counts as 1.
- Computed from live LA inputs and captured at the start event. Later LA changes do not affect the operation.

States: IDLE, BUSY, ROT, DONE.

IDLE (after reset):
- On start event at edge E0: raw, cur and best are all loaded with the raw code; EXP and mode are latched.
- Next state is BUSY if mode=0, ROT if mode=1.

BUSY (mode 0): at E1, result = raw, go to DONE.

ROT (mode 1):
- Each edge: cur = rotate-right-by-1(cur), i.e. new bit k = old bit (k+1) mod 8.
- best = unsigned min(best, new cur); cnt increments.
- After 8 edges (E1..E8), result = best, go to DONE. done is visible after E8.

DONE:
- Holds result; match = (result == EXP).
- A new start event restarts exactly as from IDLE.

Start events in BUSY/ROT are ignored; the edge detector still tracks its level.

Outputs:
- la_data_out[7:0] = raw.
- la_data_out[15:8] = result.
- la_data_out[16] = done.
- la_data_out[17] = match.
- la_data_out[18] = busy (BUSY or ROT).
- la_data_out other bits = 0.
- io_out[31:16] = {CHK_TAG, status}, where status is:
  - 0x40 in IDLE;
  - 0x41 in BUSY/ROT;
  - 0x51 in DONE with match;
  - 0x50 in DONE without match.
- io_oeb[31:16] = 0 (driven). All other io_oeb bits = 1; all other io_out bits = 0.

Reset (asynchronous, any time including mid-operation):
- State goes to IDLE; raw, cur, best, result, EXP, mode, cnt and start history are cleared.
- la_data_out = 0.
- io_out[31:16] = 0xAB40 immediately, at reset assertion and throughout reset.

All outputs are registered or decoded from registered state only; there is no combinational path from la_data_in to outputs.

Test Plan:
1. Reset asserted -> io_out[31:16]=0xAB40, la_data_out=0, io_oeb[31:16]=0, io_oeb other bits all 1; assert reset during ROT -> immediate return to 0xAB40.
2. C=0x80, P1=P4=0x80, other P=0x10, EXP=0x09, mode=1, start 0->1 -> 0xAB41 for 8 cycles, then raw=0x12, result=0x09, done=1, match=1, io[31:16]=0xAB51.
3. Same pixels, mode=0, EXP=0x12 -> result=0x12 after one BUSY cycle, 0xAB51; rerun with EXP=0x13 -> match=0, 0xAB50.
4. All P=0xFF, C=0x00, mode=1 -> result 0xFF. All P=0x00, C=0x01 -> result 0x00.
5. start held high with la_oenb[96]=1 -> no operation, stays 0xAB40. Second start pulse during ROT -> ignored, result unchanged. Start pulse in DONE -> new operation.
6. Change LA pixels while in ROT -> result equals the code from pixels captured at E0.
